demux_1x8_router: RTL

Registered 1-to-8 demultiplexer: accepts a single stream of data beats, each tagged with a 3-bit destination select, and delivers each beat to exactly one of eight output channels. Every channel has a one-entry holding register with valid/ready handshake, so a stalled destination never corrupts others. Sits on the distribution side of the design, fanning a shared bus out to eight consumers. It is the inverse of the 8:1 decoder-select mux path.

---
 rtl/demux_1x8_router.sv | 85 ++++++++
 1 files changed

// File: rtl/demux_1x8_router.sv
// Registered 1:8 demux: one beat/cycle, delivered one cycle after accept; a full, stalled channel only blocks beats aimed at it.
// Define DEMUX_AUTOSEL_EN to ignore in_sel and steer beats round-robin from an internal pointer.
module demux_1x8_router #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [2:0]       in_sel,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [8*W-1:0]   out_data,
    output logic [2:0]       last_sel,
    output logic [CW-1:0]    beat_cnt
);

    logic [7:0]          r_valid;
    logic [7:0][W-1:0]   r_data;
    logic [2:0]          r_last_sel;
    logic [CW-1:0]       r_beat_cnt;
    logic [2:0]          w_sel;
    logic [7:0]          w_dec;
    logic [7:0]          w_load;
    logic                w_accept;

`ifdef DEMUX_AUTOSEL_EN
    logic [2:0] r_ptr;
    logic       w_unused_sel;

    assign w_unused_sel = ^in_sel;
    assign w_sel        = r_ptr;

    // Pointer only moves on an accepted beat so a stalled channel is retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'd0;
        end else if (w_accept) begin
            r_ptr <= r_ptr + 3'd1;
        end
    end
`else
    assign w_sel = in_sel;
`endif

    assign w_dec    = 8'b0000_0001 << w_sel;
    assign in_ready = ~r_valid[w_sel] | out_ready[w_sel];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_dec & {8{w_accept}};

    // A load takes priority over a drain on the same channel, keeping full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 8'h00;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sel <= 3'd0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_last_sel <= w_sel;
            r_beat_cnt <= r_beat_cnt + CW'(1);
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign last_sel  = r_last_sel;
    assign beat_cnt  = r_beat_cnt;

endmodule
